// File: rtl/stump_mem_responder_pkg.sv
// Shared types and constants for the Stump memory responder.
package stump_mem_responder_pkg;

  localparam int unsigned WAIT_STATES_DEFAULT = 2;
  localparam int unsigned DATA_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  // Out-of-range word address, or a simultaneous read and write request.
  function automatic logic access_illegal(input logic [15:0] addr,
                                          input logic        ren,
                                          input logic        wen,
                                          input int unsigned abits);
    logic [15:0] hi;
    hi = addr >> abits;
    return (hi != 16'h0000) || (ren && wen);
  endfunction

endpackage

// File: rtl/stump_mem_responder_sram.sv
// Single-port synchronous SRAM; read data is held until the next read strobe.
module stump_mem_responder_sram
  import stump_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stump_mem_responder.sv
// Four-phase req/ack memory responder for the Stump processor with
// programmable wait states and illegal-access reporting.
module stump_mem_responder
  import stump_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int unsigned ADDR_BITS   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic [15:0] address_i,
  input  logic [15:0] data_in_i,
  output logic [15:0] data_out_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            wdata_q;
  logic                   rd_q;
  logic                   wr_q;
  logic                   err_q;
  logic                   ack_q;
  logic                   mem_err_q;
  logic                   busy_q;
  logic                   dout_zero_q;

  logic                   req;
  logic                   accept;
  logic                   illegal_now;
  logic                   complete;
  logic                   cmp_rd;
  logic                   cmp_wr;
  logic                   cmp_err;
  logic                   sram_en;
  logic [ADDR_BITS-1:0]   sram_addr;
  logic [15:0]            sram_wdata;
  logic [15:0]            sram_rdata;

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the access fields come straight from the inputs instead of the latches.
  always_comb begin
    req         = mem_ren_i | mem_wen_i;
    accept      = (state_q == ST_IDLE) && !ack_q && req && !rst_i;
    illegal_now = access_illegal(address_i, mem_ren_i, mem_wen_i, ADDR_BITS);
    complete    = !rst_i &&
                  ((accept && (WAIT_STATES == 0)) ||
                   ((state_q == ST_WAIT) && req && (cnt_q == 4'd1)));
    if (state_q == ST_IDLE) begin
      cmp_rd     = mem_ren_i;
      cmp_wr     = mem_wen_i;
      cmp_err    = illegal_now;
      sram_addr  = address_i[ADDR_BITS-1:0];
      sram_wdata = data_in_i;
    end else begin
      cmp_rd     = rd_q;
      cmp_wr     = wr_q;
      cmp_err    = err_q;
      sram_addr  = addr_q;
      sram_wdata = wdata_q;
    end
    sram_en = complete && !cmp_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      mem_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      dout_zero_q <= 1'b1;
    end else begin
      // Ack trails the ACK state by one cycle, which also guarantees an
      // ack-low cycle before the next accept.
      ack_q     <= (state_q == ST_ACK);
      mem_err_q <= (state_q == ST_ACK) && err_q;

      if (complete && cmp_rd) begin
        dout_zero_q <= cmp_err;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= address_i[ADDR_BITS-1:0];
            wdata_q <= data_in_i;
            rd_q    <= mem_ren_i;
            wr_q    <= mem_wen_i;
            err_q   <= illegal_now;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACK;
              cnt_q   <= 4'd0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          if (!req) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  stump_mem_responder_sram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (sram_en),
    .we_i   (cmp_wr),
    .addr_i (sram_addr),
    .wdata_i(sram_wdata),
    .rdata_o(sram_rdata)
  );

  assign data_out_o = dout_zero_q ? 16'h0000 : sram_rdata;
  assign mem_ack_o  = ack_q;
  assign mem_err_o  = mem_err_q;
  assign busy_o     = busy_q;

endmodule
